lsu_mem_arbiter: RTL and testbench
==================================

Name: lsu_mem_arbiter

Overview:
- Shares one data-memory channel among the THREADS_PER_BLOCK per-thread LSU ports inside a core.
- Sits between the per-thread LSU memory interfaces and the core's data-memory interface, and sequences one transaction at a time.
- Arbitration is round-robin with one outstanding transaction.
- Uses the valid/ready hold-until-release handshake that the LSUs already speak.

Parameters:
THREADS_PER_BLOCK, 4, number of requesting LSU ports
ADDR_BITS, 8, data-memory address width
DATA_BITS, 8, data-memory data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_read_valid  in  THREADS_PER_BLOCK  per-thread read request
req_read_address  in  THREADS_PER_BLOCK*ADDR_BITS  packed; thread i at [i*ADDR_BITS +: ADDR_BITS]
req_read_ready  out  THREADS_PER_BLOCK  per-thread read completion
req_read_data  out  THREADS_PER_BLOCK*DATA_BITS  packed read data
req_write_valid  in  THREADS_PER_BLOCK  per-thread write request
req_write_address  in  THREADS_PER_BLOCK*ADDR_BITS  packed
req_write_data  in  THREADS_PER_BLOCK*DATA_BITS  packed
req_write_ready  out  THREADS_PER_BLOCK  per-thread write completion
mem_read_valid  out  1  downstream read request
mem_read_address  out  ADDR_BITS  downstream read address
mem_read_ready  in  1  downstream read done
mem_read_data  in  DATA_BITS  downstream read data
mem_write_valid  out  1  downstream write request
mem_write_address  out  ADDR_BITS  downstream write address
mem_write_data  out  DATA_BITS  downstream write data
mem_write_ready  in  1  downstream write done
busy  out  1  1 when state != IDLE
grant_id  out  $clog2(THREADS_PER_BLOCK)  thread currently owning the channel

Behaviour:
- Reset (reset==0, async): state=IDLE, every output=0, rr_ptr=THREADS_PER_BLOCK-1 (so thread 0 has first priority), all req_*_data=0. Reset in mid-transaction drops mem_*_valid immediately and abandons the transaction.
- All outputs are registered. The FSM has four states: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- IDLE: search the threads with req_read_valid|req_write_valid, starting at rr_ptr+1 and wrapping modulo THREADS_PER_BLOCK. On a hit at index g, on the next edge:
  - grant_id=g, rr_ptr=g.
  - If req_read_valid[g]: mem_read_valid=1, mem_read_address=addr[g], go to READ_WAIT.
  - Otherwise: mem_write_valid=1, mem_write_address/data from g, go to WRITE_WAIT.
  - Read wins if one thread asserts both; its write is serviced on a later grant.
- READ_WAIT: hold mem_read_valid/address stable until mem_read_ready==1. On that edge:
  - mem_read_valid=0.
  - Slice g of req_read_data is latched from mem_read_data.
  - req_read_ready[g]=1, go to RELAY.
- WRITE_WAIT: same as READ_WAIT with the write signals. On mem_write_ready: mem_write_valid=0, req_write_ready[g]=1, go to RELAY.
- RELAY: hold req_*_ready[g] and data until the granted thread drops the valid that was served. Then clear ready, go to IDLE, busy=0.
- Only slice g of req_read_data changes. Other slices keep their values.
- Latency: request seen in IDLE at edge N gives mem valid high after edge N. Downstream ready sampled at edge M gives requester ready after edge M. Valid dropped at edge K gives IDLE after edge K, and the next grant follows at edge K+1 at the earliest.
- Fairness: after thread g is served, every other pending thread is granted before g again. Worst-case wait is (THREADS_PER_BLOCK-1) transactions.
- Valids on non-granted threads are ignored while busy. Requesters must hold valid/address until ready.
- A downstream ready arriving in IDLE or RELAY is ignored.
- Only one mem_*_valid is ever high, and never both read and write together.
- No timeout: a downstream that never returns ready stalls the arbiter. Verification treats that as an environment error.

Test Plan:
- Single read: thread 2 reads addr 0x15, memory returns 0xA7 after 3 cycles. Expected: mem_read_address=0x15, req_read_data slice 2=0xA7, req_read_ready[2] high until valid drops, grant_id=2.
- Single write: thread 1 writes 0x3C to 0x40. Expected: mem_write_address=0x40, mem_write_data=0x3C, req_write_ready[1] after mem_write_ready, busy low one cycle after valid drops.
- Round-robin: all 4 threads assert reads together from reset, and each holds valid until served. Expected grant order 0,1,2,3. Thread 0 re-requests immediately and is served only after thread 3.
- Wrap: thread 3 is served and threads 0 and 3 are both pending. Expected: 0 is granted next (pointer wraps past 3).
- Read/write priority: thread 0 asserts read 0x10 and write 0x11/0x55 together. Expected: read issued first, write on a later grant, never both mem valids high.
- Reset mid-op: pull reset low in READ_WAIT. Expected: mem_read_valid=0 asynchronously, all ready outputs 0, busy=0. After release, a pending thread 0 is granted first.

Source files
------------

// File: rtl/lsu_mem_arbiter_if.sv
// Valid/ready read+write channel bundle; PORTS lanes packed side by side.
// The LSU side uses PORTS=THREADS_PER_BLOCK, the memory side PORTS=1.
interface lsu_mem_arbiter_if #(
    parameter int unsigned PORTS     = 1,
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8
);
    logic [PORTS-1:0]           read_valid;
    logic [PORTS*ADDR_BITS-1:0] read_address;
    logic [PORTS-1:0]           read_ready;
    logic [PORTS*DATA_BITS-1:0] read_data;
    logic [PORTS-1:0]           write_valid;
    logic [PORTS*ADDR_BITS-1:0] write_address;
    logic [PORTS*DATA_BITS-1:0] write_data;
    logic [PORTS-1:0]           write_ready;

    // Requester side: raises valid and holds it until ready.
    modport master (
        output read_valid, read_address, write_valid, write_address, write_data,
        input  read_ready, read_data, write_ready
    );

    // Responder side: completes a request by raising ready.
    modport slave (
        input  read_valid, read_address, write_valid, write_address, write_data,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory channel among per-thread LSU ports,
// with a single outstanding transaction and registered outputs.
module lsu_mem_arbiter #(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned ADDR_BITS         = 8,
    parameter int unsigned DATA_BITS         = 8,
    localparam int unsigned ID_BITS = (THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1
) (
    input  logic               clk,
    input  logic               reset,
    lsu_mem_arbiter_if.slave   req,
    lsu_mem_arbiter_if.master  mem,
    output logic               busy,
    output logic [ID_BITS-1:0] grant_id
);
    localparam int unsigned N = THREADS_PER_BLOCK;

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_e;

    state_e                 state_q, state_d;
    logic [ID_BITS-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_BITS-1:0]     grant_q, grant_d;
    logic                   served_write_q, served_write_d;
    logic                   busy_q, busy_d;
    logic                   mem_read_valid_q, mem_read_valid_d;
    logic                   mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]   mem_read_address_q, mem_read_address_d;
    logic [ADDR_BITS-1:0]   mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]   mem_write_data_q, mem_write_data_d;
    logic [N-1:0]           req_read_ready_q, req_read_ready_d;
    logic [N-1:0]           req_write_ready_q, req_write_ready_d;
    logic [N*DATA_BITS-1:0] req_read_data_q, req_read_data_d;

    logic               hit_c;
    logic [ID_BITS-1:0] hit_id_c;

    // First requesting thread after rr_ptr, wrapping modulo N.
    always_comb begin
        int unsigned        sum;
        logic [ID_BITS-1:0] idx;
        hit_c    = 1'b0;
        hit_id_c = '0;
        sum      = 0;
        idx      = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            sum = 32'(rr_ptr_q) + i;
            if (sum >= N) sum = sum - N;
            idx = ID_BITS'(sum);
            if (!hit_c && (req.read_valid[idx] || req.write_valid[idx])) begin
                hit_c    = 1'b1;
                hit_id_c = idx;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d             = state_q;
        rr_ptr_d            = rr_ptr_q;
        grant_d             = grant_q;
        served_write_d      = served_write_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        req_read_ready_d    = req_read_ready_q;
        req_write_ready_d   = req_write_ready_q;
        req_read_data_d     = req_read_data_q;

        unique case (state_q)
            IDLE: begin
                if (hit_c) begin
                    grant_d  = hit_id_c;
                    rr_ptr_d = hit_id_c;
                    // A thread asserting both gets its read first.
                    if (req.read_valid[hit_id_c]) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = req.read_address[hit_id_c*ADDR_BITS +: ADDR_BITS];
                        served_write_d     = 1'b0;
                        state_d            = READ_WAIT;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = req.write_address[hit_id_c*ADDR_BITS +: ADDR_BITS];
                        mem_write_data_d    = req.write_data[hit_id_c*DATA_BITS +: DATA_BITS];
                        served_write_d      = 1'b1;
                        state_d             = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem.read_ready[0]) begin
                    mem_read_valid_d = 1'b0;
                    req_read_data_d[grant_q*DATA_BITS +: DATA_BITS] = mem.read_data;
                    req_read_ready_d[grant_q] = 1'b1;
                    state_d = RELAY;
                end
            end
            WRITE_WAIT: begin
                if (mem.write_ready[0]) begin
                    mem_write_valid_d          = 1'b0;
                    req_write_ready_d[grant_q] = 1'b1;
                    state_d                    = RELAY;
                end
            end
            RELAY: begin
                // Release only once the served valid is dropped.
                if (served_write_q ? !req.write_valid[grant_q] : !req.read_valid[grant_q]) begin
                    req_read_ready_d[grant_q]  = 1'b0;
                    req_write_ready_d[grant_q] = 1'b0;
                    state_d                    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= IDLE;
            rr_ptr_q            <= ID_BITS'(N - 1);
            grant_q             <= '0;
            served_write_q      <= 1'b0;
            busy_q              <= 1'b0;
            mem_read_valid_q    <= 1'b0;
            mem_write_valid_q   <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            req_read_ready_q    <= '0;
            req_write_ready_q   <= '0;
            req_read_data_q     <= '0;
        end else begin
            state_q             <= state_d;
            rr_ptr_q            <= rr_ptr_d;
            grant_q             <= grant_d;
            served_write_q      <= served_write_d;
            busy_q              <= busy_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            req_read_ready_q    <= req_read_ready_d;
            req_write_ready_q   <= req_write_ready_d;
            req_read_data_q     <= req_read_data_d;
        end
    end

    assign busy              = busy_q;
    assign grant_id          = grant_q;
    assign mem.read_valid    = mem_read_valid_q;
    assign mem.read_address  = mem_read_address_q;
    assign mem.write_valid   = mem_write_valid_q;
    assign mem.write_address = mem_write_address_q;
    assign mem.write_data    = mem_write_data_q;
    assign req.read_ready    = req_read_ready_q;
    assign req.write_ready   = req_write_ready_q;
    assign req.read_data     = req_read_data_q;
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Scoreboard bench for lsu_mem_arbiter: directed requests push expected memory
// transactions and requester completions; a negedge monitor pops and compares.
module tb_lsu_mem_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [1:0] grant_id;

    always #5 clk = ~clk;

    lsu_mem_arbiter_if #(.PORTS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) lif ();
    lsu_mem_arbiter_if #(.PORTS(1), .ADDR_BITS(AW), .DATA_BITS(DW)) mif ();

    lsu_mem_arbiter #(.THREADS_PER_BLOCK(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk(clk), .reset(reset), .req(lif.slave), .mem(mif.master),
        .busy(busy), .grant_id(grant_id)
    );

    typedef struct {
        bit          wr;
        int unsigned tid;
        logic [7:0]  addr;
        logic [7:0]  data;
    } txn_t;

    txn_t mem_q[$];
    txn_t rsp_q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_mem(input bit wr, input int unsigned t, input logic [7:0] a, input logic [7:0] d);
        txn_t e;
        e.wr = wr; e.tid = t; e.addr = a; e.data = d;
        mem_q.push_back(e);
    endtask

    task automatic push_rsp(input bit wr, input int unsigned t, input logic [7:0] d);
        txn_t e;
        e.wr = wr; e.tid = t; e.addr = 8'h00; e.data = d;
        rsp_q.push_back(e);
    endtask

    // Memory model: data = addr ^ 0x5A except where preset or written.
    logic [7:0] mem_arr [256];
    int         mem_lat = 2;

    initial begin
        int cnt;
        for (int a = 0; a < 256; a++) mem_arr[a] = 8'(a) ^ 8'h5A;
        mem_arr[8'h15]  = 8'hA7;
        mif.read_ready  = 1'b0;
        mif.write_ready = 1'b0;
        mif.read_data   = 8'h00;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (mif.read_ready[0] || mif.write_ready[0]) begin
                mif.read_ready  = 1'b0;
                mif.write_ready = 1'b0;
                cnt = 0;
            end else if (reset && (mif.read_valid[0] || mif.write_valid[0])) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    if (mif.read_valid[0]) begin
                        mif.read_data  = mem_arr[mif.read_address];
                        mif.read_ready = 1'b1;
                    end else begin
                        mem_arr[mif.write_address] = mif.write_data;
                        mif.write_ready = 1'b1;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: compares each new mem transaction and each requester completion.
    logic         prev_rv, prev_wv;
    logic [N-1:0] prev_rr, prev_wr;
    logic [7:0]   hold_addr;
    logic [7:0]   exp_rdata [N];

    always @(negedge clk) begin
        txn_t            e;
        logic [N*DW-1:0] v;
        if (!reset) begin
            prev_rv = 1'b0; prev_wv = 1'b0; prev_rr = '0; prev_wr = '0;
            for (int t = 0; t < N; t++) exp_rdata[t] = 8'h00;
        end else begin
            if ((mif.read_valid[0] && !prev_rv) || (mif.write_valid[0] && !prev_wv)) begin
                chk("mem_valid_exclusive", 64'(mif.read_valid[0] & mif.write_valid[0]), 64'(0));
                chk("mem_txn_expected", 64'(mem_q.size() != 0), 64'(1));
                if (mem_q.size() != 0) begin
                    e = mem_q.pop_front();
                    chk("mem_kind_is_write", 64'(mif.write_valid[0]), 64'(e.wr));
                    chk("mem_addr", 64'(e.wr ? mif.write_address : mif.read_address), 64'(e.addr));
                    if (e.wr) chk("mem_write_data", 64'(mif.write_data), 64'(e.data));
                    chk("grant_id", 64'(grant_id), 64'(e.tid));
                end
                hold_addr = mif.read_address;
            end else if (mif.read_valid[0] && prev_rv) begin
                chk("mem_read_addr_stable", 64'(mif.read_address), 64'(hold_addr));
            end
            for (int t = 0; t < N; t++) begin
                if ((lif.read_ready[t] && !prev_rr[t]) || (lif.write_ready[t] && !prev_wr[t])) begin
                    chk("rsp_expected", 64'(rsp_q.size() != 0), 64'(1));
                    if (rsp_q.size() != 0) begin
                        e = rsp_q.pop_front();
                        chk("rsp_thread", 64'(t), 64'(e.tid));
                        chk("rsp_kind_is_write", 64'(lif.write_ready[t]), 64'(e.wr));
                        if (!e.wr) exp_rdata[e.tid] = e.data;
                        for (int k = 0; k < N; k++) v[k*DW +: DW] = exp_rdata[k];
                        chk("req_read_data_all_slices", 64'(lif.read_data), 64'(v));
                    end
                end
            end
            prev_rv = mif.read_valid[0];
            prev_wv = mif.write_valid[0];
            prev_rr = lif.read_ready;
            prev_wr = lif.write_ready;
        end
    end

    task automatic drive_read(input int unsigned t, input logic [7:0] a);
        int n;
        lif.read_valid[t] = 1'b1;
        lif.read_address[t*AW +: AW] = a;
        n = 0;
        do begin @(negedge clk); n++; end while (!lif.read_ready[t] && n < 200);
        chk($sformatf("rd_done_t%0d", t), 64'(lif.read_ready[t]), 64'(1));
        @(negedge clk);
        chk($sformatf("rd_ready_held_t%0d", t), 64'(lif.read_ready[t]), 64'(1));
        lif.read_valid[t] = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_write(input int unsigned t, input logic [7:0] a, input logic [7:0] d);
        int n;
        lif.write_valid[t] = 1'b1;
        lif.write_address[t*AW +: AW] = a;
        lif.write_data[t*DW +: DW] = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!lif.write_ready[t] && n < 200);
        chk($sformatf("wr_done_t%0d", t), 64'(lif.write_ready[t]), 64'(1));
        @(negedge clk);
        chk($sformatf("wr_ready_held_t%0d", t), 64'(lif.write_ready[t]), 64'(1));
        lif.write_valid[t] = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        lif.read_valid = '0; lif.read_address = '0;
        lif.write_valid = '0; lif.write_address = '0; lif.write_data = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_mem_valids", 64'({mif.read_valid, mif.write_valid}), 64'(0));
        chk("rst_req_readies", 64'({lif.read_ready, lif.write_ready}), 64'(0));
        chk("rst_req_read_data", 64'(lif.read_data), 64'(0));
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        // Single read: thread 2, addr 0x15, data 0xA7 after 3 cycles.
        mem_lat = 3;
        push_mem(1'b0, 2, 8'h15, 8'h00); push_rsp(1'b0, 2, 8'hA7);
        drive_read(2, 8'h15);

        // Single write: thread 1, 0x3C to 0x40; busy low one cycle after drop.
        mem_lat = 2;
        push_mem(1'b1, 1, 8'h40, 8'h3C); push_rsp(1'b1, 1, 8'h00);
        drive_write(1, 8'h40, 8'h3C);
        chk("busy_after_drop", 64'(busy), 64'(0));

        // Round-robin from reset: 0,1,2,3 then thread 0 again.
        pulse_reset();
        push_mem(1'b0, 0, 8'h20, 8'h00); push_rsp(1'b0, 0, 8'h7A);
        push_mem(1'b0, 1, 8'h21, 8'h00); push_rsp(1'b0, 1, 8'h7B);
        push_mem(1'b0, 2, 8'h22, 8'h00); push_rsp(1'b0, 2, 8'h78);
        push_mem(1'b0, 3, 8'h23, 8'h00); push_rsp(1'b0, 3, 8'h79);
        push_mem(1'b0, 0, 8'h24, 8'h00); push_rsp(1'b0, 0, 8'h7E);
        fork
            begin drive_read(0, 8'h20); drive_read(0, 8'h24); end
            drive_read(1, 8'h21);
            drive_read(2, 8'h22);
            drive_read(3, 8'h23);
        join

        // Wrap: thread 3 served (reads back the earlier write), then 0 beats 3.
        push_mem(1'b0, 3, 8'h40, 8'h00); push_rsp(1'b0, 3, 8'h3C);
        drive_read(3, 8'h40);
        push_mem(1'b0, 0, 8'h30, 8'h00); push_rsp(1'b0, 0, 8'h6A);
        push_mem(1'b0, 3, 8'h31, 8'h00); push_rsp(1'b0, 3, 8'h6B);
        fork
            drive_read(0, 8'h30);
            drive_read(3, 8'h31);
        join

        // Same thread read+write: read first, write on a later grant.
        push_mem(1'b0, 0, 8'h10, 8'h00); push_rsp(1'b0, 0, 8'h4A);
        push_mem(1'b1, 0, 8'h11, 8'h55); push_rsp(1'b1, 0, 8'h00);
        fork
            drive_read(0, 8'h10);
            drive_write(0, 8'h11, 8'h55);
        join

        // Reset during READ_WAIT with thread 0 waiting behind thread 2.
        mem_lat = 20;
        push_mem(1'b0, 2, 8'h22, 8'h00);
        lif.read_valid[2] = 1'b1;
        lif.read_address[2*AW +: AW] = 8'h22;
        n = 0;
        do begin @(negedge clk); n++; end while (!busy && n < 50);
        chk("mid_op_busy", 64'(busy), 64'(1));
        lif.read_valid[0] = 1'b1;
        lif.read_address[0 +: AW] = 8'h05;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_mem_read_valid", 64'(mif.read_valid[0]), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_readies", 64'({lif.read_ready, lif.write_ready}), 64'(0));
        chk("midrst_grant_id", 64'(grant_id), 64'(0));
        mem_lat = 2;
        push_mem(1'b0, 0, 8'h05, 8'h00); push_rsp(1'b0, 0, 8'h5F);
        push_mem(1'b0, 2, 8'h22, 8'h00); push_rsp(1'b0, 2, 8'h78);
        @(negedge clk);
        #2 reset = 1'b1;
        fork
            drive_read(0, 8'h05);
            drive_read(2, 8'h22);
        join

        repeat (3) @(negedge clk);
        chk("mem_q_drained", 64'(mem_q.size()), 64'(0));
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, checks);
        $fatal(1, "timeout");
    end
endmodule
